// File: rtl/i2c_pkg.sv
`default_nettype none
// ==================================================================
// Package : i2c_pkg -- shared states and constants for the I2C master
// Rev     : 1.0
// ==================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    WR,
    ACK_W,
    RD,
    NACK_R,
    STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int         BITS     = 8;
  localparam logic [2:0] LAST_BIT = 3'(BITS - 1);

endpackage
`default_nettype wire

// File: rtl/i2c_phase_gen.sv
`default_nettype none
// ==================================================================
// Module : i2c_phase_gen -- CLK_DIV divider and bit-slot quarter index
// Rev    : 1.0
// ==================================================================
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       freeze,
  output logic       quarter_tick,
  output logic [1:0] quarter
);

  localparam int              CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;

  always_comb begin
    cnt_d        = cnt_q;
    quarter_d    = quarter_q;
    quarter_tick = 1'b0;
    if (!en) begin
      cnt_d     = '0;
      quarter_d = Q0;
    end else if (!freeze) begin
      if (cnt_q == CNT_LAST) begin
        quarter_tick = 1'b1;
        cnt_d        = '0;
        quarter_d    = quarter_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quarter_q <= Q0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

  assign quarter = quarter_q;

endmodule
`default_nettype wire

// File: rtl/i2c_master_controller.sv
`default_nettype none
// ==================================================================
// Module : i2c_master_controller -- single-byte open-drain I2C master
// Rev    : 1.0
// ==================================================================
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] data_wr,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  state_t     state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] wr_byte_q, wr_byte_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_rd_q, data_rd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ack_err_q, ack_err_d;
  logic       sda_oe_q, sda_oe_d;
  logic       scl_oe_q, scl_oe_d;

  logic [1:0] quarter, quarter_nxt;
  logic       quarter_tick, slot_end, sample_pt, scl_low_nxt;
  logic       sda_in, scl_in, freeze;

  assign sda_in = sda;
  assign scl_in = scl;
  // A slave holding SCL low after release stretches the high phase.
  assign freeze = (quarter == Q2) && !scl_in;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (state_q != IDLE),
    .freeze       (freeze),
    .quarter_tick (quarter_tick),
    .quarter      (quarter)
  );

  assign slot_end    = quarter_tick && (quarter == Q3);
  assign sample_pt   = quarter_tick && (quarter == Q2);
  assign quarter_nxt = quarter_tick ? quarter + 2'd1 : quarter;
  assign scl_low_nxt = (quarter_nxt == Q0) || (quarter_nxt == Q1);

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    wr_byte_d = wr_byte_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_rd_d = data_rd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;

    case (state_q)
      IDLE: begin
        // The cycle carrying done still refuses a new command.
        if (start && !done_q) begin
          state_d   = START;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          rw_d      = rw;
          wr_byte_d = data_wr;
          shift_d   = {addr, rw};
          bit_cnt_d = 3'd0;
        end
      end
      START: if (slot_end) state_d = ADDR;
      ADDR, WR: begin
        if (slot_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 3'd0;
            state_d   = (state_q == ADDR) ? ACK_A : ACK_W;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
      ACK_A: begin
        if (sample_pt && sda_in) ack_err_d = 1'b1;
        if (slot_end) begin
          if (ack_err_q) begin
            state_d = STOP;
          end else if (rw_q == RW_READ) begin
            state_d = RD;
          end else begin
            state_d = WR;
            shift_d = wr_byte_q;
          end
        end
      end
      ACK_W: begin
        if (sample_pt && sda_in) ack_err_d = 1'b1;
        if (slot_end) state_d = STOP;
      end
      RD: begin
        if (sample_pt) shift_d = {shift_q[6:0], sda_in};
        if (slot_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = 3'd0;
            data_rd_d = shift_q;
            state_d   = NACK_R;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      NACK_R: if (slot_end) state_d = STOP;
      STOP: begin
        if (slot_end) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin drives are computed for the slot/quarter about to begin so they register cleanly.
    sda_oe_d = 1'b0;
    scl_oe_d = 1'b0;
    case (state_d)
      START: sda_oe_d = (quarter_nxt == Q2) || (quarter_nxt == Q3);
      ADDR, WR: begin
        scl_oe_d = scl_low_nxt;
        sda_oe_d = !shift_d[7];
      end
      ACK_A, ACK_W, RD, NACK_R: scl_oe_d = scl_low_nxt;
      STOP: begin
        scl_oe_d = scl_low_nxt;
        sda_oe_d = (quarter_nxt != Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rw_q      <= RW_WRITE;
      wr_byte_q <= 8'h00;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      data_rd_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      wr_byte_q <= wr_byte_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_rd_q <= data_rd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      sda_oe_q  <= sda_oe_d;
      scl_oe_q  <= scl_oe_d;
    end
  end

  assign sda     = sda_oe_q ? 1'b0 : 1'bz;
  assign scl     = scl_oe_q ? 1'b0 : 1'bz;
  assign data_rd = data_rd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_controller.sv
`default_nettype none
// ==================================================================
// Module : tb_i2c_master_controller -- directed bench with slave model
// Rev    : 1.0
// ==================================================================
module tb_i2c_master_controller;

  localparam int         CLK_DIV    = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h45;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] data_wr = 8'h00;
  wire  [7:0] data_rd;
  wire        busy, done, ack_err;
  wire        sda, scl;

  logic slave_sda_low = 1'b0;
  logic scl_hold = 1'b0;
  logic [7:0] slave_rd_byte = 8'h00;

  pullup (sda);
  pullup (scl);
  assign sda = slave_sda_low ? 1'b0 : 1'bz;
  assign scl = scl_hold ? 1'b0 : 1'bz;

  i2c_master_controller #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .sda     (sda),
    .scl     (scl)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor and slave at SLAVE_ADDR; captured entries are {byte, ninth bit}.
  logic [8:0] cap[$];
  int   nstart = 0, nstop = 0, n_done = 0;
  logic p_sda = 1'b1, p_scl = 1'b1;
  logic in_frame = 1'b0, matched = 1'b0, rd_mode = 1'b0;
  logic [7:0] sh = 8'h00;
  int   bitcnt = 0, byte_idx = 0;

  always @(negedge clk) begin : mon
    logic s, c;
    s = (sda === 1'b0) ? 1'b0 : 1'b1;
    c = (scl === 1'b0) ? 1'b0 : 1'b1;
    if (done === 1'b1) n_done++;
    if (p_scl && c && p_sda && !s) begin
      in_frame = 1'b1; bitcnt = 0; byte_idx = 0; matched = 1'b0;
      slave_sda_low = 1'b0; nstart++;
    end else if (p_scl && c && !p_sda && s) begin
      in_frame = 1'b0; slave_sda_low = 1'b0; nstop++;
    end else if (in_frame && !p_scl && c) begin
      if (bitcnt < 8) sh = {sh[6:0], s};
      bitcnt++;
      if (bitcnt == 8 && byte_idx == 0) begin
        matched = (sh[7:1] == SLAVE_ADDR);
        rd_mode = sh[0];
      end
      if (bitcnt == 9) begin
        cap.push_back({sh, s});
        bitcnt = 0;
        byte_idx++;
      end
    end else if (in_frame && p_scl && !c) begin
      slave_sda_low = 1'b0;
      if (matched) begin
        if (bitcnt == 8 && (byte_idx == 0 || (byte_idx == 1 && !rd_mode)))
          slave_sda_low = 1'b1;
        else if (byte_idx == 1 && rd_mode && bitcnt < 8)
          slave_sda_low = !slave_rd_byte[7 - bitcnt];
      end
    end
    p_sda = s;
    p_scl = c;
  end

  // Entered at the first negedge after the accepting edge; returns in the done cycle.
  task automatic wait_done(input int guard_at, input int hold_on, input int hold_off,
                           output int cycles);
    int k = 0;
    while (done !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
      if (k == guard_at) begin
        start = 1'b1; addr = 7'h12; rw = 1'b1; data_wr = 8'hFF;
      end
      if (k == guard_at + 1) start = 1'b0;
      if (k == hold_on)  scl_hold = 1'b1;
      if (k == hold_off) scl_hold = 1'b0;
    end
    cycles = k;
  endtask

  task automatic do_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                        input logic [7:0] srd, input int guard_at, input int hold_on,
                        input int hold_off, output int cycles);
    cap.delete();
    nstart = 0;
    nstop = 0;
    slave_rd_byte = srd;
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; data_wr = d;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ack_err_cleared", ack_err, 0);
    wait_done(guard_at, hold_on, hold_off, cycles);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wr;
    logic [7:0] srd;
    int         cyc;
    logic       aerr;
    logic [7:0] drd;
    int         nbytes;
    logic [8:0] b0;
    logic [8:0] b1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cyc;

    vecs[0] = '{1'b0, 7'h45, 8'hA5, 8'h00, 320, 1'b0, 8'h00, 2, {8'h8A, 1'b0}, {8'hA5, 1'b0}};
    vecs[1] = '{1'b1, 7'h45, 8'h00, 8'hCC, 320, 1'b0, 8'hCC, 2, {8'h8B, 1'b0}, {8'hCC, 1'b1}};
    vecs[2] = '{1'b1, 7'h45, 8'h00, 8'h01, 320, 1'b0, 8'h01, 2, {8'h8B, 1'b0}, {8'h01, 1'b1}};
    vecs[3] = '{1'b0, 7'h2A, 8'h5A, 8'h00, 176, 1'b1, 8'h01, 1, {8'h54, 1'b1}, 9'h000};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_data_rd", data_rd, 8'h00);
    chk("rst_sda", sda, 1);
    chk("rst_scl", scl, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wr, vecs[i].srd, -1, -1, -1, cyc);
      chk($sformatf("v%0d_latency", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      chk($sformatf("v%0d_ack_err", i), ack_err, vecs[i].aerr);
      chk($sformatf("v%0d_data_rd", i), data_rd, vecs[i].drd);
      chk($sformatf("v%0d_nbytes", i), cap.size(), vecs[i].nbytes);
      if (cap.size() > 0) chk($sformatf("v%0d_byte0", i), cap[0], vecs[i].b0);
      if (vecs[i].nbytes > 1 && cap.size() > 1) chk($sformatf("v%0d_byte1", i), cap[1], vecs[i].b1);
      chk($sformatf("v%0d_nstart", i), nstart, 1);
      chk($sformatf("v%0d_nstop", i), nstop, 1);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Second start while busy must not disturb the write in progress.
    n_done = 0;
    do_txn(1'b0, 7'h45, 8'h3C, 8'h00, 50, -1, -1, cyc);
    repeat (20) @(negedge clk);
    chk("guard_latency", cyc, 320);
    chk("guard_done_count", n_done, 1);
    chk("guard_nbytes", cap.size(), 2);
    if (cap.size() > 1) begin
      chk("guard_addr_byte", cap[0], {8'h8A, 1'b0});
      chk("guard_data_byte", cap[1], {8'h3C, 1'b0});
    end

    // Slave holds SCL for 10 frozen clocks inside the ACK_A high phase.
    do_txn(1'b0, 7'h45, 8'hA5, 8'h00, -1, 148, 162, cyc);
    chk("stretch_latency", cyc, 330);
    chk("stretch_ack_err", ack_err, 0);
    chk("stretch_nbytes", cap.size(), 2);
    if (cap.size() > 1) chk("stretch_data_byte", cap[1], {8'hA5, 1'b0});

    // Start raised in the done cycle is accepted one cycle later.
    cap.delete();
    nstart = 0;
    slave_rd_byte = 8'h96;
    start = 1'b1; rw = 1'b1; addr = 7'h45;
    @(negedge clk);
    chk("b2b_ignored_in_done", busy, 0);
    @(negedge clk);
    chk("b2b_accepted", busy, 1);
    start = 1'b0;
    wait_done(-1, -1, -1, cyc);
    chk("b2b_latency", cyc, 320);
    chk("b2b_data_rd", data_rd, 8'h96);
    chk("b2b_nstart", nstart, 1);

    // Reset while the 3rd data bit (a 0) is being driven.
    repeat (3) @(negedge clk);
    cap.delete();
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h45; data_wr = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (197) @(negedge clk);
    chk("pre_rst_sda_low", sda, 0);
    chk("pre_rst_scl_low", scl, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sda", sda, 1);
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data_rd", data_rd, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(1'b0, 7'h45, 8'hA5, 8'h00, -1, -1, -1, cyc);
    chk("post_rst_latency", cyc, 320);
    chk("post_rst_nstart", nstart, 1);
    chk("post_rst_nbytes", cap.size(), 2);
    if (cap.size() > 1) begin
      chk("post_rst_addr_byte", cap[0], {8'h8A, 1'b0});
      chk("post_rst_data_byte", cap[1], {8'hA5, 1'b0});
    end
    chk("post_rst_ack_err", ack_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
